// File: rtl/id_retire_arbiter.sv
// rtl/id_retire_arbiter.sv - round-robin arbiter for the shared writeback/retire port
module id_retire_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int ID_W      = 3,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UNITS-1:0]        unit_valid,
    input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
    input  logic [NUM_UNITS*5-1:0]      unit_rd_addr,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
    output logic [NUM_UNITS-1:0]        unit_ack,
    input  logic                        retire_hold,
    output logic                        retired,
    output logic [ID_W-1:0]             ids_retiring,
    output logic [4:0]                  retired_rd_addr,
    output logic                        retired_we,
    output logic [DATA_W-1:0]           retired_data,
    output logic [15:0]                 retired_total
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       offset;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       next_ptr;
    logic [PTR_W:0]         idx_sum;
    logic [2*NUM_UNITS-1:0] valid_dbl;
    logic [NUM_UNITS-1:0]   valid_rot;
    logic                   grant_any;
    logic [ID_W-1:0]        sel_id;
    logic [4:0]             sel_rd;
    logic [DATA_W-1:0]      sel_data;

    // Rotate the request vector so bit 0 is the unit at rr_ptr, then take the
    // lowest set bit; the offset is mapped back to an absolute unit index.
    always_comb begin
        valid_dbl = {unit_valid, unit_valid};
        valid_rot = valid_dbl[rr_ptr +: NUM_UNITS];
        offset    = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                offset = PTR_W'(i);
            end
        end
        idx_sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (idx_sum >= (PTR_W+1)'(NUM_UNITS)) begin
            idx_sum = idx_sum - (PTR_W+1)'(NUM_UNITS);
        end
        grant_idx = idx_sum[PTR_W-1:0];
        grant_any = rst && !retire_hold && (|unit_valid);
        unit_ack  = '0;
        if (grant_any) begin
            unit_ack[grant_idx] = 1'b1;
        end
        if (grant_idx == PTR_W'(NUM_UNITS - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + PTR_W'(1);
        end
    end

    always_comb begin
        sel_id   = unit_id[grant_idx*ID_W +: ID_W];
        sel_rd   = unit_rd_addr[grant_idx*5 +: 5];
        sel_data = unit_data[grant_idx*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr          <= '0;
            retired         <= 1'b0;
            retired_we      <= 1'b0;
            ids_retiring    <= '0;
            retired_rd_addr <= '0;
            retired_data    <= '0;
            retired_total   <= '0;
        end else begin
            retired    <= grant_any;
            // A retire to x0 still frees its ID but must not write the file.
            retired_we <= grant_any && (sel_rd != 5'd0);
            if (grant_any) begin
                rr_ptr          <= next_ptr;
                ids_retiring    <= sel_id;
                retired_rd_addr <= sel_rd;
                retired_data    <= sel_data;
            end
            if (retired) begin
                retired_total <= retired_total + 16'd1;
            end
        end
    end

endmodule

// File: doc/id_retire_arbiter.md
# id_retire_arbiter

Shares the single writeback/retire port of the ID management logic among the functional units that complete register-writing instructions. Each cycle it selects one completing unit by round-robin, acknowledges it, and presents that unit's ID, rd address and result on a registered retire port. That port drives `retired[0]`/`ids_retiring[0]` of ID management and the register file write port. It also keeps a running retired-instruction count for performance counters.

## Interface

Parameters:
- `NUM_UNITS`, 4: number of completing requesters (≥2).
- `ID_W`, 3: instruction ID width, equal to log2 of the maximum in-flight ID count.
- `DATA_W`, 32: result width.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst`=0 at a rising edge resets).
- `unit_valid`  in  NUM_UNITS  unit i has a completed result pending.
- `unit_id`  in  NUM_UNITS*ID_W  ID of unit i's result, in slice [i*ID_W +: ID_W].
- `unit_rd_addr`  in  NUM_UNITS*5  destination register of unit i.
- `unit_data`  in  NUM_UNITS*DATA_W  result of unit i.
- `unit_ack`  out  NUM_UNITS  one-hot grant; unit i's result is consumed this cycle.
- `retire_hold`  in  1  global control stall; suppresses all grants.
- `retired`  out  1  retire port valid, registered.
- `ids_retiring`  out  ID_W  ID being retired.
- `retired_rd_addr`  out  5  destination register.
- `retired_we`  out  1  register file write enable; `retired` and rd≠0.
- `retired_data`  out  DATA_W  write data.
- `retired_total`  out  16  count of retires since reset, wrapping.

## Operation

- Handshake: a unit raises `unit_valid[i]` with its payload and holds both stable until it sees `unit_ack[i]`=1 at a rising edge. Ack is the only transfer condition. A unit may present a new result in the cycle after its ack.
- State: round-robin pointer `rr_ptr` (log2 NUM_UNITS bits, range 0..NUM_UNITS-1), the output register set, and `retired_total`.
- Grant (combinational): if `rst`=1, `retire_hold`=0 and any `unit_valid` is set, grant the first valid unit found scanning `rr_ptr`, `rr_ptr`+1, … modulo NUM_UNITS. At most one `unit_ack` bit is set. `unit_ack` is 0 when no unit is valid, when `retire_hold`=1, or when `rst`=0.
- Pointer update: on a grant to unit g, `rr_ptr` ← (g+1) mod NUM_UNITS, so g wraps to 0 when it equals NUM_UNITS-1. With no grant, `rr_ptr` holds.
- Output register: on a grant, capture `retired`=1 together with the granted unit's id, rd and data. With no grant, `retired`=0 and the payload registers hold their last values.
- `retired_we` is registered as (grant & rd≠0). A retire to x0 still asserts `retired`, so the ID is freed, but performs no write.
- `retired_total` increments by 1 on each cycle where registered `retired`=1, and wraps from 0xFFFF to 0.
- Fairness: with all units continuously valid and no hold, each unit is granted exactly once in every NUM_UNITS consecutive cycles.

## Timing

- Reset (`rst`=0 at an edge): `retired`=0, `retired_we`=0, `ids_retiring`=0, `retired_rd_addr`=0, `retired_data`=0, `retired_total`=0, `rr_ptr`=0. `unit_ack` is 0 combinationally while `rst`=0.
- Reset mid-operation: any result captured in the output register is dropped. Upstream flush and ID re-initialisation own recovery.
- Latency: `unit_ack` is asserted in the same cycle as the grant decision. `retired` and the payload appear on the next rising edge, exactly one cycle after the ack. Throughput is one retire per cycle.
- `retire_hold` takes effect the same cycle: no ack is issued, and `retired`=0 on the following cycle. A held unit keeps `unit_valid` asserted.
- Simultaneous events:
  - A unit acked at edge N may assert a new `unit_valid` immediately after edge N. That result competes in cycle N+1 behind the rotated pointer.
  - `retired_total` counts the registered `retired`, so the count lags the ack by 2 edges.

## Test plan

- Reset then idle: hold `rst`=0 for 2 cycles, release, keep all `unit_valid`=0 → all outputs 0, `retired_total`=0.
- Single requester: unit 2 valid with id=5, rd=7, data=0xDEADBEEF → `unit_ack`=4'b0100 in that cycle; next cycle `retired`=1, `ids_retiring`=5, `retired_rd_addr`=7, `retired_we`=1, `retired_data`=0xDEADBEEF.
- Round-robin wrap: all 4 units continuously valid for 8 cycles from reset → ack order 0,1,2,3,0,1,2,3; `retired_total`=8 two cycles after the last ack.
- Hold: all units valid, `retire_hold`=1 for 3 cycles → no ack, `retired`=0 and `rr_ptr` unchanged; on release the unit at `rr_ptr` is granted first.
- x0 retire: unit 1 valid with rd=0 → `retired`=1, `retired_we`=0, counter increments.
- Reset mid-stream: assert `rst`=0 in the cycle after an ack → `retired`=0 next edge, `retired_total`=0, first post-reset grant goes to unit 0.
